// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver (8N1, optional parity) that pushes good bytes into the RX FIFO.
// Define UART_RX_PARITY_EN to add a parity bit, the PARITY state and the PARERR port.
`timescale 1ns/1ps

module uart_rx_os #(
  parameter int DIV_W      = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  input  logic             RX,
  input  logic             ISFULL,
  output logic             WRITE,
  output logic [7:0]       DATA,
  output logic             FRAMEERR,
  output logic             OVERRUN,
`ifdef UART_RX_PARITY_EN
  output logic             PARERR,
`endif
  output logic             BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t           state, state_n;
  logic             rx_meta, rxs;
  logic [DIV_W-1:0] div_eff, tick_cnt;
  logic             tick, start_go;
  logic [3:0]       scnt, scnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shr, shr_n, data_n;
  logic             armed, armed_n;
  logic             s7, s7_n, s8, s8_n, vote;
  logic             write_n, fe_n, ov_n;
`ifdef UART_RX_PARITY_EN
  logic             par_bad, par_bad_n, parerr_n;
`else
  logic             unused_parity_cfg;
  assign unused_parity_cfg = PARITY_ODD;
`endif

  // Synchroniser idles high so reset never looks like a start edge.
  // NOTE: every clocked process uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
    end
  end

  // Oversample tick; a divisor of 0 behaves as 1, and >= tolerates a divisor shrunk mid-count.
  assign div_eff = (DIV == '0) ? DIV_W'(1) : DIV;
  assign tick    = (tick_cnt >= div_eff - DIV_W'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                         tick_cnt <= '0;
    else if (!EN || start_go || tick) tick_cnt <= '0;
    else                             tick_cnt <= tick_cnt + DIV_W'(1);
  end

  // Majority of the three centre samples; the third sample is the live one at SCNT=9.
  assign vote = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_n  = state;
    scnt_n   = scnt;
    bit_n    = bit_idx;
    shr_n    = shr;
    armed_n  = armed;
    s7_n     = s7;
    s8_n     = s8;
    data_n   = DATA;
    write_n  = 1'b0;
    fe_n     = 1'b0;
    ov_n     = 1'b0;
    start_go = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    parerr_n  = 1'b0;
`endif
    if (!EN) begin
      state_n = ST_IDLE;
      armed_n = 1'b0;
    end else if (tick) begin
      if (state != ST_IDLE) begin
        scnt_n = scnt + 4'd1;
        if (scnt == 4'd7) s7_n = rxs;
        if (scnt == 4'd8) s8_n = rxs;
      end
      case (state)
        ST_IDLE: begin
          if (rxs) armed_n = 1'b1;
          else if (armed) begin
            state_n  = ST_START;
            scnt_n   = 4'd0;
            start_go = 1'b1;
          end
        end
        ST_START: begin
          if (scnt == 4'd9 && vote) state_n = ST_IDLE;
          else if (scnt == 4'd15) begin
            state_n = ST_DATA;
            bit_n   = 3'd0;
          end
        end
        ST_DATA: begin
          if (scnt == 4'd9) shr_n = {vote, shr[7:1]};
          if (scnt == 4'd15) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end else begin
              bit_n = bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (scnt == 4'd9)  par_bad_n = (vote != (PARITY_ODD ? ~^shr : ^shr));
          if (scnt == 4'd15) state_n   = ST_STOP;
        end
`endif
        ST_STOP: begin
          // Leave at mid-stop so the next start edge is never missed.
          if (scnt == 4'd9) begin
            state_n = ST_IDLE;
            if (!vote) begin
              fe_n    = 1'b1;
              armed_n = 1'b0;
            end else if (ISFULL) begin
              ov_n = 1'b1;
`ifdef UART_RX_PARITY_EN
              parerr_n = par_bad;
`endif
            end else begin
              data_n  = shr;
              write_n = 1'b1;
`ifdef UART_RX_PARITY_EN
              parerr_n = par_bad;
`endif
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      scnt     <= 4'd0;
      bit_idx  <= 3'd0;
      shr      <= 8'h00;
      armed    <= 1'b0;
      s7       <= 1'b1;
      s8       <= 1'b1;
      DATA     <= 8'h00;
      WRITE    <= 1'b0;
      FRAMEERR <= 1'b0;
      OVERRUN  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
      PARERR   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      scnt     <= scnt_n;
      bit_idx  <= bit_n;
      shr      <= shr_n;
      armed    <= armed_n;
      s7       <= s7_n;
      s8       <= s8_n;
      DATA     <= data_n;
      WRITE    <= write_n;
      FRAMEERR <= fe_n;
      OVERRUN  <= ov_n;
`ifdef UART_RX_PARITY_EN
      par_bad  <= par_bad_n;
      PARERR   <= parerr_n;
`endif
    end
  end

  assign BUSY = (state != ST_IDLE);

endmodule
